riscv_store_ctrl: RTL and testbench
===================================

Name: riscv_store_ctrl

Overview:
- Sequences store-data transfers from the EX/MEM stage onto the data-memory write bus.
- Takes the raw rs2 value, store width (MASK_SEL) and byte address, then does the following:
  - applies the byte/half/word data mask;
  - lane-aligns the data;
  - generates byte strobes;
  - runs a valid/ready handshake with memory.
- Splits a word-crossing misaligned store into two beats, or flags it as an error.
- Sits between the pipeline store path and the data-memory port; stalls the pipeline while busy.

Parameters:
- WORD_LENGTH, 32, datapath and address width; only 32 is supported.
- SPLIT_EN, 1, 1 = split word-crossing stores into two beats; 0 = report misalign error, no bus traffic.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  controller can accept a request.
- req_addr  input  WORD_LENGTH  byte address of the store.
- req_data  input  WORD_LENGTH  raw rs2 data.
- req_mask_sel  input  MASK_SEL  MASK_B = byte, MASK_H = half, MASK_X = word.
- mem_valid  output  1  write beat valid.
- mem_ready  input  1  memory accepts the beat.
- mem_addr  output  WORD_LENGTH  word-aligned beat address (bits [1:0] = 0).
- mem_wdata  output  WORD_LENGTH  lane-aligned write data.
- mem_wstrb  output  4  byte write enables.
- done  output  1  one-cycle pulse: store retired (success or error).
- misalign_err  output  1  one-cycle pulse coincident with done on a rejected store.
- stall  output  1  high while a store is in flight (state != IDLE).

Behaviour:
- Reset (async): state = IDLE.
  - All of these are 0: mem_valid, mem_addr, mem_wdata, mem_wstrb, done, misalign_err, stall.
  - req_ready = 1.
- States: IDLE, BEAT0, BEAT1, ERR.
- Acceptance:
  - req_ready = (state == IDLE), combinational from state.
  - A request is captured on a clock edge where req_valid && req_ready.
- Byte count: MASK_B = 1, MASK_H = 2, MASK_X = 4.
- Data mask: the low 8/16/32 bits of req_data are kept; upper bits are zeroed.
- Alignment, with off = req_addr[1:0]:
  - 64-bit shifted data = {32'b0, masked} << (8*off).
  - 8-bit strobe = ((1 << bytes) - 1) << off.
  - Beat0: addr = {req_addr[31:2], 2'b00}; data = shifted[31:0]; strb = strobe[3:0].
  - Beat1: addr = beat0 addr + 4 (wraps modulo 2^32); data = shifted[63:32]; strb = strobe[7:4].
  - A store needs a split iff strobe[7:4] != 0.
- Transitions from IDLE on acceptance:
  - Invalid MASK_SEL encoding -> ERR.
  - Split needed and SPLIT_EN == 0 -> ERR.
  - Otherwise -> BEAT0.
- BEAT0 / BEAT1:
  - All mem_* outputs are registered, loaded on the state-entry edge.
  - mem_valid = 1 in these states.
  - mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready is sampled high.
  - BEAT0 on handshake: go to BEAT1 if split needed, else go to IDLE with done pulse.
  - BEAT1 on handshake: go to IDLE with done pulse.
- ERR:
  - Lasts exactly one cycle; mem_valid = 0 throughout.
  - On exit -> IDLE; done = 1 and misalign_err = 1 for the next cycle.
- done / misalign_err:
  - Registered, high for exactly one cycle after the retiring edge.
  - In that cycle state is already IDLE, so req_ready = 1 and back-to-back acceptance is allowed.
  - Minimum latency: aligned store with mem_ready tied high takes acceptance + 1 beat cycle; done follows.
- mem_valid deasserts on the edge after the final handshake unless a new beat is loaded. It never glitches mid-beat.
- stall = (state != IDLE).
- Mid-operation reset: everything returns to reset values immediately. The in-flight beat is abandoned; no done pulse.
- Capture: req_* are sampled only at acceptance. Later changes to the request inputs do not affect the in-flight store.

Test Plan:
- Aligned word: addr = 0x100, data = 0xDEADBEEF, MASK_X, mem_ready = 1 -> one beat, mem_addr = 0x100, wdata = 0xDEADBEEF, wstrb = 4'b1111; done 2 cycles after acceptance; misalign_err = 0.
- Byte lane: addr = 0x203, data = 0x123456AB, MASK_B -> mem_addr = 0x200, wdata = 0xAB000000, wstrb = 4'b1000.
- Split half (SPLIT_EN = 1): addr = 0x07, data = 0xFFFFCAFE, MASK_H -> beat0: addr 0x04, wdata 0xFE000000, wstrb 4'b1000; beat1: addr 0x08, wdata 0x000000CA, wstrb 4'b0001; single done.
- Back-pressure: aligned half at 0x12 (data 0x0000BEEF, MASK_H), mem_ready low for 3 cycles -> mem_valid/addr 0x10/wdata 0xBEEF0000/wstrb 4'b1100 held stable for 4 cycles; stall high throughout; req_ready low.
- Error (SPLIT_EN = 0): addr = 0x0E, MASK_X -> no mem_valid ever; done = misalign_err = 1 for one cycle 2 cycles after acceptance; a following request is accepted in that same cycle.
- Reset mid-beat: assert rst while in BEAT1 with mem_ready = 0 -> mem_valid, stall and done immediately 0; req_ready = 1; no done pulse after release.

Source files
------------

// File: rtl/riscv_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_store_ctrl
// Brief    : Masks, lane-aligns and strobes EX/MEM store data onto the data
//            memory write bus, splitting word-crossing stores into two beats.
// Revision : 1.0  initial release
// ============================================================================
module riscv_store_ctrl #(
    parameter int WORD_LENGTH = 32,
    parameter bit SPLIT_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WORD_LENGTH-1:0] req_addr,
    input  logic [WORD_LENGTH-1:0] req_data,
    input  logic [1:0]             req_mask_sel,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    output logic [3:0]             mem_wstrb,
    output logic                   done,
    output logic                   misalign_err,
    output logic                   stall
);

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_X = 2'b10;
    localparam logic [WORD_LENGTH-1:0] C_WORD_BYTES = WORD_LENGTH'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_mem_valid;
    logic [WORD_LENGTH-1:0]   r_mem_addr;
    logic [WORD_LENGTH-1:0]   r_mem_wdata;
    logic [3:0]               r_mem_wstrb;
    logic                     r_done;
    logic                     r_misalign_err;
    logic                     r_split;
    logic [WORD_LENGTH-1:0]   r_b1_data;
    logic [3:0]               r_b1_strb;

    logic                     w_sel_bad;
    logic [WORD_LENGTH-1:0]   w_masked;
    logic [3:0]               w_bytes_mask;
    logic [2*WORD_LENGTH-1:0] w_shifted;
    logic [7:0]               w_strobe;
    logic                     w_split;

    always_comb begin
        w_sel_bad    = 1'b0;
        w_masked     = req_data;
        w_bytes_mask = 4'b1111;
        case (req_mask_sel)
            MASK_B: begin
                w_masked     = {{(WORD_LENGTH-8){1'b0}}, req_data[7:0]};
                w_bytes_mask = 4'b0001;
            end
            MASK_H: begin
                w_masked     = {{(WORD_LENGTH-16){1'b0}}, req_data[15:0]};
                w_bytes_mask = 4'b0011;
            end
            MASK_X: begin
                w_masked     = req_data;
                w_bytes_mask = 4'b1111;
            end
            default: w_sel_bad = 1'b1;
        endcase
    end

    // Shift into a two-word window; the upper word is the spill-over beat.
    assign w_shifted = {{WORD_LENGTH{1'b0}}, w_masked} << {req_addr[1:0], 3'b000};
    assign w_strobe  = {4'b0000, w_bytes_mask} << req_addr[1:0];
    assign w_split   = |w_strobe[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_mem_valid    <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_wstrb    <= 4'b0000;
            r_done         <= 1'b0;
            r_misalign_err <= 1'b0;
            r_split        <= 1'b0;
            r_b1_data      <= '0;
            r_b1_strb      <= 4'b0000;
        end else begin
            r_done         <= 1'b0;
            r_misalign_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_sel_bad || (w_split && !SPLIT_EN)) begin
                            r_state <= ERR;
                        end else begin
                            r_state     <= BEAT0;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {req_addr[WORD_LENGTH-1:2], 2'b00};
                            r_mem_wdata <= w_shifted[WORD_LENGTH-1:0];
                            r_mem_wstrb <= w_strobe[3:0];
                            r_split     <= w_split;
                            r_b1_data   <= w_shifted[2*WORD_LENGTH-1:WORD_LENGTH];
                            r_b1_strb   <= w_strobe[7:4];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (r_split) begin
                            r_state     <= BEAT1;
                            r_mem_addr  <= r_mem_addr + C_WORD_BYTES;
                            r_mem_wdata <= r_b1_data;
                            r_mem_wstrb <= r_b1_strb;
                        end else begin
                            r_state     <= IDLE;
                            r_mem_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        r_state     <= IDLE;
                        r_mem_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                ERR: begin
                    r_state        <= IDLE;
                    r_done         <= 1'b1;
                    r_misalign_err <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign stall        = (r_state != IDLE);
    assign mem_valid    = r_mem_valid;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wstrb    = r_mem_wstrb;
    assign done         = r_done;
    assign misalign_err = r_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_riscv_store_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_riscv_store_ctrl
// Brief    : Bench for riscv_store_ctrl; one split and one non-split instance
//            share stimulus and are checked against a byte-level store model.
// Revision : 1.0  initial release
// ============================================================================
module tb_riscv_store_ctrl;

    localparam logic [1:0] MB = 2'b00;
    localparam logic [1:0] MH = 2'b01;
    localparam logic [1:0] MX = 2'b10;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        req_valid    = 1'b0;
    logic        mem_ready    = 1'b0;
    logic [31:0] req_addr     = '0;
    logic [31:0] req_data     = '0;
    logic [1:0]  req_mask_sel = '0;

    logic [1:0]  req_ready, mem_valid, done, misalign_err, stall;
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Index 0: SPLIT_EN = 0, index 1: SPLIT_EN = 1
    riscv_store_ctrl #(.WORD_LENGTH(32), .SPLIT_EN(1'b0)) u_nosplit (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_data(req_data), .req_mask_sel(req_mask_sel),
        .mem_valid(mem_valid[0]), .mem_ready(mem_ready), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .done(done[0]),
        .misalign_err(misalign_err[0]), .stall(stall[0])
    );

    riscv_store_ctrl #(.WORD_LENGTH(32), .SPLIT_EN(1'b1)) u_split (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_data(req_data), .req_mask_sel(req_mask_sel),
        .mem_valid(mem_valid[1]), .mem_ready(mem_ready), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .done(done[1]),
        .misalign_err(misalign_err[1]), .stall(stall[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Walk the store byte by byte and drop each byte into the word it lands in.
    function automatic void compute(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [1:0] sel,
                                    output logic [31:0] a0, output logic [31:0] d0,
                                    output logic [3:0] s0, output logic [31:0] a1,
                                    output logic [31:0] d1, output logic [3:0] s1,
                                    output int nb, output bit bad);
        int          nbytes;
        int          lane;
        logic [31:0] a;
        bad    = (sel == 2'b11);
        nbytes = (sel == MB) ? 1 : (sel == MH) ? 2 : 4;
        a0 = {addr[31:2], 2'b00};
        a1 = a0 + 32'd4;
        d0 = '0; d1 = '0; s0 = '0; s1 = '0;
        for (int i = 0; i < nbytes; i++) begin
            a    = addr + 32'(i);
            lane = int'(a[1:0]);
            if (a[31:2] == addr[31:2]) begin
                d0[8*lane +: 8] = data[8*i +: 8];
                s0[lane]        = 1'b1;
            end else begin
                d1[8*lane +: 8] = data[8*i +: 8];
                s1[lane]        = 1'b1;
            end
        end
        nb = (s1 != 4'b0000) ? 2 : 1;
    endfunction

    // Reference: per instance, a list of outstanding beats plus a pending error.
    int          m_n    [2] = '{0, 0};
    bit          m_err  [2] = '{1'b0, 1'b0};
    bit          m_done [2] = '{1'b0, 1'b0};
    bit          m_merr [2] = '{1'b0, 1'b0};
    logic [31:0] m_a [2][2];
    logic [31:0] m_d [2][2];
    logic [3:0]  m_s [2][2];

    always @(posedge clk or posedge rst) begin
        logic [31:0] a0, d0, a1, d1;
        logic [3:0]  s0, s1;
        int          nb;
        bit          bad;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_n[k] = 0; m_err[k] = 1'b0; m_done[k] = 1'b0; m_merr[k] = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                m_merr[k] = 1'b0;
                if (m_n[k] > 0) begin
                    if (mem_ready) begin
                        m_a[k][0] = m_a[k][1];
                        m_d[k][0] = m_d[k][1];
                        m_s[k][0] = m_s[k][1];
                        m_n[k]--;
                        if (m_n[k] == 0) m_done[k] = 1'b1;
                    end
                end else if (m_err[k]) begin
                    m_err[k]  = 1'b0;
                    m_done[k] = 1'b1;
                    m_merr[k] = 1'b1;
                end else if (req_valid) begin
                    compute(req_addr, req_data, req_mask_sel, a0, d0, s0, a1, d1, s1, nb, bad);
                    if (bad || (nb == 2 && k == 0)) begin
                        m_err[k] = 1'b1;
                    end else begin
                        m_a[k][0] = a0; m_d[k][0] = d0; m_s[k][0] = s0;
                        m_a[k][1] = a1; m_d[k][1] = d1; m_s[k][1] = s1;
                        m_n[k] = nb;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit busy;
        for (int k = 0; k < 2; k++) begin
            busy = (m_n[k] > 0) || m_err[k];
            chk($sformatf("u%0d.req_ready", k), 32'(req_ready[k]), 32'(!busy));
            chk($sformatf("u%0d.stall", k), 32'(stall[k]), 32'(busy));
            chk($sformatf("u%0d.mem_valid", k), 32'(mem_valid[k]), 32'(m_n[k] > 0));
            chk($sformatf("u%0d.done", k), 32'(done[k]), 32'(m_done[k]));
            chk($sformatf("u%0d.misalign_err", k), 32'(misalign_err[k]), 32'(m_merr[k]));
            if (m_n[k] > 0) begin
                chk($sformatf("u%0d.mem_addr", k), mem_addr[k], m_a[k][0]);
                chk($sformatf("u%0d.mem_wdata", k), mem_wdata[k], m_d[k][0]);
                chk($sformatf("u%0d.mem_wstrb", k), 32'(mem_wstrb[k]), 32'(m_s[k][0]));
            end
        end
    end

    task automatic next_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid    = 1'b1;
        req_addr     = a;
        req_data     = d;
        req_mask_sel = s;
    endtask

    task automatic beat(input string name, input int k, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        chk({name, ".valid"}, 32'(mem_valid[k]), 32'd1);
        chk({name, ".addr"}, mem_addr[k], a);
        chk({name, ".wdata"}, mem_wdata[k], d);
        chk({name, ".wstrb"}, 32'(mem_wstrb[k]), 32'(s));
    endtask

    initial begin
        logic [31:0] a0, d0, a1, d1;
        logic [3:0]  s0, s1;
        int          nb;
        bit          bad;

        // Hand-computed pins on the model itself
        compute(32'h0000_0007, 32'hFFFF_CAFE, MH, a0, d0, s0, a1, d1, s1, nb, bad);
        chk("model.split.a0", a0, 32'h4);
        chk("model.split.d0", d0, 32'hFE00_0000);
        chk("model.split.a1", a1, 32'h8);
        chk("model.split.d1", d1, 32'h0000_00CA);
        chk("model.split.nb", 32'(nb), 32'd2);
        compute(32'hFFFF_FFFF, 32'h0000_BEEF, MH, a0, d0, s0, a1, d1, s1, nb, bad);
        chk("model.wrap.a1", a1, 32'h0);
        chk("model.wrap.s1", 32'(s1), 32'h1);
        compute(32'h0000_0203, 32'h1234_56AB, MB, a0, d0, s0, a1, d1, s1, nb, bad);
        chk("model.byte.d0", d0, 32'hAB00_0000);
        chk("model.byte.nb", 32'(nb), 32'd1);

        // Reset state
        repeat (2) next_neg();
        for (int k = 0; k < 2; k++) begin
            chk("rst.req_ready", 32'(req_ready[k]), 32'd1);
            chk("rst.mem_valid", 32'(mem_valid[k]), 32'd0);
            chk("rst.mem_addr", mem_addr[k], 32'd0);
            chk("rst.mem_wdata", mem_wdata[k], 32'd0);
            chk("rst.mem_wstrb", 32'(mem_wstrb[k]), 32'd0);
            chk("rst.done", 32'(done[k]), 32'd0);
            chk("rst.stall", 32'(stall[k]), 32'd0);
        end
        rst = 1'b0;
        next_neg();

        // Aligned word
        mem_ready = 1'b1;
        set_req(32'h100, 32'hDEAD_BEEF, MX);
        next_neg();
        req_valid = 1'b0;
        beat("word", 1, 32'h100, 32'hDEAD_BEEF, 4'b1111);
        next_neg();
        chk("word.done", 32'(done[1]), 32'd1);
        chk("word.err", 32'(misalign_err[1]), 32'd0);
        chk("word.valid_off", 32'(mem_valid[1]), 32'd0);

        // Byte lane
        set_req(32'h203, 32'h1234_56AB, MB);
        next_neg();
        req_valid = 1'b0;
        beat("byte", 1, 32'h200, 32'hAB00_0000, 4'b1000);
        next_neg();
        chk("byte.done", 32'(done[1]), 32'd1);

        // Split half (instance 1 splits, instance 0 rejects)
        set_req(32'h07, 32'hFFFF_CAFE, MH);
        next_neg();
        req_valid = 1'b0;
        beat("split.b0", 1, 32'h04, 32'hFE00_0000, 4'b1000);
        chk("nosplit.valid", 32'(mem_valid[0]), 32'd0);
        chk("nosplit.stall", 32'(stall[0]), 32'd1);
        next_neg();
        beat("split.b1", 1, 32'h08, 32'h0000_00CA, 4'b0001);
        chk("split.no_early_done", 32'(done[1]), 32'd0);
        chk("nosplit.done", 32'(done[0]), 32'd1);
        chk("nosplit.err", 32'(misalign_err[0]), 32'd1);
        next_neg();
        chk("split.done", 32'(done[1]), 32'd1);
        chk("nosplit.single_done", 32'(done[0]), 32'd0);

        // Back-pressure: ready low for 3 cycles
        mem_ready = 1'b0;
        set_req(32'h12, 32'h0000_BEEF, MH);
        next_neg();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_neg();
            beat("bp", 1, 32'h10, 32'hBEEF_0000, 4'b1100);
            chk("bp.stall", 32'(stall[1]), 32'd1);
            chk("bp.req_ready", 32'(req_ready[1]), 32'd0);
            if (i == 3) mem_ready = 1'b1;
        end
        next_neg();
        chk("bp.done", 32'(done[1]), 32'd1);

        // Error with back-to-back acceptance on the non-split instance
        set_req(32'h0E, 32'hA5A5_A5A5, MX);
        next_neg();
        set_req(32'h20, 32'h1122_3344, MX);
        chk("err.valid", 32'(mem_valid[0]), 32'd0);
        next_neg();
        chk("err.done", 32'(done[0]), 32'd1);
        chk("err.flag", 32'(misalign_err[0]), 32'd1);
        chk("err.req_ready", 32'(req_ready[0]), 32'd1);
        chk("err.valid2", 32'(mem_valid[0]), 32'd0);
        next_neg();
        req_valid = 1'b0;
        beat("b2b", 0, 32'h20, 32'h1122_3344, 4'b1111);
        repeat (4) next_neg();

        // Reset in the middle of beat 1
        set_req(32'h07, 32'hFFFF_CAFE, MH);
        next_neg();
        req_valid = 1'b0;
        next_neg();
        beat("rstmid.b1", 1, 32'h08, 32'h0000_00CA, 4'b0001);
        mem_ready = 1'b0;
        next_neg();
        rst = 1'b1;
        #1;
        chk("rstmid.valid", 32'(mem_valid[1]), 32'd0);
        chk("rstmid.stall", 32'(stall[1]), 32'd0);
        chk("rstmid.done", 32'(done[1]), 32'd0);
        chk("rstmid.req_ready", 32'(req_ready[1]), 32'd1);
        next_neg();
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_neg();
            chk("rstmid.no_done", 32'(done[1]), 32'd0);
        end

        // Randomized traffic, requests changing freely while busy
        for (int i = 0; i < 1500; i++) begin
            next_neg();
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                    : $urandom;
            req_data     = $urandom;
            req_mask_sel = 2'($urandom_range(0, 3));
            mem_ready    = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (4) next_neg();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
